// File: rtl/boot_loader.sv
// Byte-stream boot loader: fills program/data memory from a host byte source
// and holds the core in reset until a RUN command arrives.
module boot_loader #(
  parameter int INST_SIZE       = 16,
  parameter int DATA_SIZE       = 32,
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int DATA_ADDR_WIDTH = 10,
  parameter logic [INST_SIZE-1:0] HALT_WORD = INST_SIZE'(16'hFFFF)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       prog_write,
  output logic [PROG_ADDR_WIDTH-1:0] prog_address,
  output logic [INST_SIZE-1:0]       prog_data,
  output logic                       data_write,
  output logic [DATA_ADDR_WIDTH-1:0] data_address,
  output logic [DATA_SIZE-1:0]       data_data,
  output logic                       core_hold,
  output logic                       error
);

  localparam int BUF_W = (INST_SIZE > DATA_SIZE) ? INST_SIZE : DATA_SIZE;
  localparam int PB    = INST_SIZE / 8;
  localparam int DB    = DATA_SIZE / 8;

  localparam logic [7:0] CMD_PROG  = 8'hA1;
  localparam logic [7:0] CMD_DATA  = 8'hA2;
  localparam logic [7:0] CMD_CLEAR = 8'hA3;
  localparam logic [7:0] CMD_RUN   = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_COUNT,
    S_PAYLOAD,
    S_CLEAR
  } state_t;

  state_t             state, state_d;
  logic               accept;
  logic               is_prog;
  logic [15:0]        addr;
  logic [8:0]         count;
  logic [7:0]         byte_idx;
  logic [7:0]         byte_last;
  logic               last_byte;
  logic [BUF_W-1:0]   buf_q, word_d;

  assign in_ready  = (state != S_CLEAR);
  assign accept    = in_valid && in_ready;
  assign byte_last = is_prog ? 8'(PB - 1) : 8'(DB - 1);
  assign last_byte = (byte_idx == byte_last);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    word_d  = buf_q;
    for (int i = 0; i < BUF_W / 8; i++) begin
      if (byte_idx == 8'(i)) word_d[i*8 +: 8] = in_data;
    end
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (in_data)
            CMD_PROG,
            CMD_DATA:  state_d = S_ADDR_LO;
            CMD_CLEAR: state_d = S_CLEAR;
            default:   state_d = S_IDLE;
          endcase
        end
      end
      S_ADDR_LO: if (accept) state_d = S_ADDR_HI;
      S_ADDR_HI: if (accept) state_d = S_COUNT;
      S_COUNT:   if (accept) state_d = S_PAYLOAD;
      S_PAYLOAD: begin
        if (accept && last_byte && count == 9'd1) state_d = S_IDLE;
      end
      S_CLEAR: if (prog_address == '1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prog_write   <= 1'b0;
      prog_address <= '0;
      prog_data    <= '0;
      data_write   <= 1'b0;
      data_address <= '0;
      data_data    <= '0;
      core_hold    <= 1'b1;
      error        <= 1'b0;
      is_prog      <= 1'b0;
      addr         <= '0;
      count        <= '0;
      byte_idx     <= '0;
      buf_q        <= '0;
    end else begin
      prog_write <= 1'b0;
      data_write <= 1'b0;
      error      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (in_data)
              CMD_PROG: begin
                is_prog   <= 1'b1;
                core_hold <= 1'b1;
              end
              CMD_DATA: begin
                is_prog   <= 1'b0;
                core_hold <= 1'b1;
              end
              CMD_CLEAR: begin
                core_hold    <= 1'b1;
                prog_write   <= 1'b1;
                prog_address <= '0;
                prog_data    <= HALT_WORD;
              end
              CMD_RUN: core_hold <= 1'b0;
              default: error <= 1'b1;
            endcase
          end
        end
        S_ADDR_LO: if (accept) addr[7:0] <= in_data;
        S_ADDR_HI: if (accept) addr[15:8] <= in_data;
        S_COUNT: begin
          if (accept) begin
            count    <= {in_data == 8'd0, in_data};
            byte_idx <= '0;
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            buf_q <= word_d;
            if (last_byte) begin
              byte_idx <= '0;
              count    <= count - 9'd1;
              addr     <= addr + 16'd1;
              if (is_prog) begin
                prog_write   <= 1'b1;
                prog_address <= addr[PROG_ADDR_WIDTH-1:0];
                prog_data    <= word_d[INST_SIZE-1:0];
              end else begin
                data_write   <= 1'b1;
                data_address <= addr[DATA_ADDR_WIDTH-1:0];
                data_data    <= word_d[DATA_SIZE-1:0];
              end
            end else begin
              byte_idx <= byte_idx + 8'd1;
            end
          end
        end
        S_CLEAR: begin
          // prog_address doubles as the sweep counter
          if (prog_address != '1) begin
            prog_write   <= 1'b1;
            prog_address <= prog_address + 1'b1;
            prog_data    <= HALT_WORD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: load, wrap, clear sweep, run/hold,
// bad command and mid-frame reset.
module tb_boot_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        prog_write;
  logic [9:0]  prog_address;
  logic [15:0] prog_data;
  logic        data_write;
  logic [9:0]  data_address;
  logic [31:0] data_data;
  logic        core_hold;
  logic        error;

  int errors = 0;
  int checks = 0;
  int n_prog = 0;
  int n_data = 0;
  int n_err  = 0;

  boot_loader dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .prog_write   (prog_write),
    .prog_address (prog_address),
    .prog_data    (prog_data),
    .data_write   (data_write),
    .data_address (data_address),
    .data_data    (data_data),
    .core_hold    (core_hold),
    .error        (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (prog_write) n_prog++;
    if (data_write) n_data++;
    if (error)      n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    int p0, d0, bad;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    step();
    step();
    chk("rst_hold", 32'(core_hold), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_pw", 32'(prog_write), 32'd0);
    chk("rst_dw", 32'(data_write), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_pa", 32'(prog_address), 32'd0);
    chk("rst_dd", data_data, 32'd0);
    reset = 1'b0;
    step();

    // 1: single data word
    put(8'hA2); put(8'h10); put(8'h00); put(8'h01);
    put(8'h80); put(8'h00); put(8'h00);
    chk("t1_pre", 32'(data_write), 32'd0);
    put(8'h00);
    chk("t1_dw", 32'(data_write), 32'd1);
    chk("t1_da", 32'(data_address), 32'h010);
    chk("t1_dd", data_data, 32'h0000_0080);
    chk("t1_hold", 32'(core_hold), 32'd1);
    idle();
    chk("t1_dw_end", 32'(data_write), 32'd0);
    chk("t1_ndata", n_data, 32'd1);

    // 2: program words with address wrap
    p0 = n_prog;
    put(8'hA1); put(8'hFF); put(8'h03); put(8'h02);
    put(8'h34);
    chk("t2_nopw", 32'(prog_write), 32'd0);
    put(8'h12);
    chk("t2_pw0", 32'(prog_write), 32'd1);
    chk("t2_pa0", 32'(prog_address), 32'h3FF);
    chk("t2_pd0", 32'(prog_data), 32'h1234);
    put(8'h78);
    chk("t2_gap", 32'(prog_write), 32'd0);
    put(8'h56);
    chk("t2_pw1", 32'(prog_write), 32'd1);
    chk("t2_pa1", 32'(prog_address), 32'h000);
    chk("t2_pd1", 32'(prog_data), 32'h5678);
    idle();
    idle();
    chk("t2_nstrobe", n_prog - p0, 32'd2);

    // 3: clear sweep
    p0 = n_prog;
    bad = 0;
    put(8'hA3);
    in_valid = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      if (prog_write !== 1'b1 || prog_address !== 10'(i) ||
          prog_data !== 16'hFFFF || in_ready !== 1'b0)
        bad++;
      step();
    end
    chk("t3_sweep_bad", bad, 32'd0);
    chk("t3_ready", 32'(in_ready), 32'd1);
    chk("t3_pw_end", 32'(prog_write), 32'd0);
    chk("t3_nstrobe", n_prog - p0, 32'd1024);
    chk("t3_hold", 32'(core_hold), 32'd1);

    // 4: run, then reload re-asserts hold
    put(8'hA5);
    chk("t4_run", 32'(core_hold), 32'd0);
    put(8'hA1);
    chk("t4_rehold", 32'(core_hold), 32'd1);
    put(8'h00); put(8'h00); put(8'h01); put(8'hAA); put(8'hBB);
    chk("t4_pw", 32'(prog_write), 32'd1);
    chk("t4_pa", 32'(prog_address), 32'h000);
    chk("t4_pd", 32'(prog_data), 32'hBBAA);
    idle();

    // 5: bad command
    p0 = n_prog;
    d0 = n_data;
    put(8'h42);
    chk("t5_err", 32'(error), 32'd1);
    idle();
    chk("t5_err_end", 32'(error), 32'd0);
    chk("t5_nowrite", (n_prog - p0) + (n_data - d0), 32'd0);
    put(8'hA5);
    chk("t5_run", 32'(core_hold), 32'd0);
    chk("t5_err_run", 32'(error), 32'd0);
    idle();
    chk("t5_nerr", n_err, 32'd1);

    // 6: reset mid-frame
    d0 = n_data;
    put(8'hA2); put(8'h20); put(8'h00); put(8'h01);
    put(8'h11); put(8'h22);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6_hold", 32'(core_hold), 32'd1);
    chk("t6_ready", 32'(in_ready), 32'd1);
    chk("t6_dw", 32'(data_write), 32'd0);
    chk("t6_da", 32'(data_address), 32'd0);
    chk("t6_dd", data_data, 32'd0);
    chk("t6_pd", 32'(prog_data), 32'd0);
    step();
    reset = 1'b0;
    idle();
    idle();
    chk("t6_nopartial", n_data - d0, 32'd0);
    put(8'hA2); put(8'h05); put(8'h00); put(8'h01);
    put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    chk("t6_dw2", 32'(data_write), 32'd1);
    chk("t6_da2", 32'(data_address), 32'h005);
    chk("t6_dd2", data_data, 32'h0403_0201);
    idle();
    chk("t6_ndata", n_data - d0, 32'd1);
    chk("t6_nerr", n_err, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
